// File: rtl/wave_player_pkg.sv
// wave_player_pkg: shared state encoding and reset constants for wave_player.
package wave_player_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_LOAD  = 3'd1,
        ST_READY = 3'd2,
        ST_PLAY  = 3'd3,
        ST_DONE  = 3'd4
    } state_e;

    localparam state_e RST_STATE = ST_IDLE;
    // Output masking is active out of reset so data reads 0 until the first sample.
    localparam logic   RST_ZERO  = 1'b1;

endpackage

// File: rtl/wave_ram.sv
// wave_ram: simple dual-port synchronous RAM, DATA_W x 2^ADDR_W,
// one write port and one registered read port.
module wave_ram #(
    parameter int DATA_W = 9,
    parameter int ADDR_W = 8
) (
    input  logic              clk,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              rd_en,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [DATA_W-1:0] rd_data
);

    logic [DATA_W-1:0] mem_q [0:(2**ADDR_W)-1];
    logic [DATA_W-1:0] rd_data_q;

    // Write port and registered read port; no reset so it maps onto block RAM.
    always_ff @(posedge clk) begin
        if (wr_en) mem_q[wr_addr] <= wr_data;
        if (rd_en) rd_data_q <= mem_q[rd_addr];
    end

    assign rd_data = rd_data_q;

endmodule

// File: rtl/wave_player.sv
// wave_player: single-channel arbitrary-waveform playback engine.
// A table is loaded through a valid/ready port, then replayed at a sample
// period of rate_div+1 clocks, looping or (optionally) once.
// Optional feature macro: WAVE_PLAYER_ONESHOT_EN enables oneshot and the DONE state.
//
// Load handshake: a sample transfers on every rising clock where wr_valid and
// wr_ready are both high. wr_ready is high exactly while the FSM is in LOAD and
// does not depend on wr_valid; wr_valid may be raised or dropped at any time.
module wave_player
    import wave_player_pkg::*;
#(
    parameter int DATA_W = 9,
    parameter int ADDR_W = 8,
    parameter int DIV_W  = 32
) (
    input  logic              sys_clk,
    input  logic              rst,
    input  logic              load_start,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              wr_valid,
    input  logic              wr_last,
    output logic              wr_ready,
    input  logic              play_en,
    input  logic [DIV_W-1:0]  rate_div,
    input  logic              oneshot,
    output logic [DATA_W-1:0] data,
    output logic              data_v,
    output logic              loaded,
    output logic              playing,
    output logic              done,
    output logic [2:0]        state_dbg
);

    state_e             state_q, state_d;
    logic [ADDR_W-1:0]  wptr_q, wptr_d;
    logic [ADDR_W-1:0]  rptr_q, rptr_d;
    logic [ADDR_W:0]    len_q, len_d;
    logic [DIV_W-1:0]   div_q, div_d;
    logic [DIV_W-1:0]   rate_q, rate_d;
    logic               fin_q, fin_d;
    logic               zero_q, zero_d;
    logic               wr_ready_q, wr_ready_d;
    logic               loaded_q, loaded_d;
    logic               playing_q, playing_d;
    logic               done_q, done_d;
    logic               data_v_q, data_v_d;

    logic               oneshot_en;
    logic               wr_hs;
    logic               tick;
    logic               rd_en;
    logic               wr_en;
    logic [DATA_W-1:0]  ram_rd_data;

`ifdef WAVE_PLAYER_ONESHOT_EN
    assign oneshot_en = oneshot;
`else
    logic unused_oneshot;
    assign oneshot_en     = 1'b0;
    assign unused_oneshot = oneshot;
`endif

    assign wr_hs = wr_ready_q && wr_valid;
    assign wr_en = wr_hs && !load_start;
    // fin_q freezes the divider once the final one-shot read has been issued.
    assign tick  = (state_q == ST_PLAY) && play_en && !fin_q && (div_q == rate_q);
    assign rd_en = tick && !load_start;

    wave_ram #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W)
    ) u_ram (
        .clk     (sys_clk),
        .wr_en   (wr_en),
        .wr_addr (wptr_q),
        .wr_data (wr_data),
        .rd_en   (rd_en),
        .rd_addr (rptr_q),
        .rd_data (ram_rd_data)
    );

    // Next-state logic: FSM transitions, pointers, divider and registered outputs.
    always_comb begin
        state_d = state_q;
        wptr_d  = wptr_q;
        rptr_d  = rptr_q;
        len_d   = len_q;
        div_d   = div_q;
        rate_d  = rate_q;
        fin_d   = fin_q;
        zero_d  = zero_q;

        if (load_start) begin
            state_d = ST_LOAD;
            wptr_d  = '0;
            rptr_d  = '0;
            fin_d   = 1'b0;
            zero_d  = 1'b1;
        end else begin
            case (state_q)
                ST_LOAD: begin
                    if (wr_hs) begin
                        wptr_d = wptr_q + 1'b1;
                        // The last address closes the table even without wr_last.
                        if (wr_last || (wptr_q == '1)) begin
                            len_d   = {1'b0, wptr_q} + 1'b1;
                            state_d = ST_READY;
                        end
                    end
                end
                ST_READY: begin
                    if (play_en) begin
                        state_d = ST_PLAY;
                        rptr_d  = '0;
                        div_d   = '0;
                        rate_d  = rate_div;
                        fin_d   = 1'b0;
                    end
                end
                ST_PLAY: begin
                    if (!play_en) begin
                        state_d = ST_READY;
                        rptr_d  = '0;
                        fin_d   = 1'b0;
                    end else if (fin_q) begin
                        state_d = ST_DONE;
                    end else if (tick) begin
                        div_d  = '0;
                        rate_d = rate_div;
                        // The RAM read register now carries a real sample.
                        zero_d = 1'b0;
                        if ({1'b0, rptr_q} == (len_q - 1'b1)) begin
                            rptr_d = '0;
                            if (oneshot_en) fin_d = 1'b1;
                        end else begin
                            rptr_d = rptr_q + 1'b1;
                        end
                    end else begin
                        div_d = div_q + 1'b1;
                    end
                end
                ST_DONE: begin
                    if (!play_en) state_d = ST_READY;
                end
                default: ;
            endcase
        end

        wr_ready_d = (state_d == ST_LOAD);
        loaded_d   = (state_d == ST_READY) || (state_d == ST_PLAY) || (state_d == ST_DONE);
        playing_d  = (state_d == ST_PLAY);
        done_d     = (state_d == ST_DONE);
        data_v_d   = rd_en;
    end

    // State and output registers with asynchronous active-high reset.
    always_ff @(posedge sys_clk or posedge rst) begin
        if (rst) begin
            state_q    <= RST_STATE;
            wptr_q     <= '0;
            rptr_q     <= '0;
            len_q      <= '0;
            div_q      <= '0;
            rate_q     <= '0;
            fin_q      <= 1'b0;
            zero_q     <= RST_ZERO;
            wr_ready_q <= 1'b0;
            loaded_q   <= 1'b0;
            playing_q  <= 1'b0;
            done_q     <= 1'b0;
            data_v_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            wptr_q     <= wptr_d;
            rptr_q     <= rptr_d;
            len_q      <= len_d;
            div_q      <= div_d;
            rate_q     <= rate_d;
            fin_q      <= fin_d;
            zero_q     <= zero_d;
            wr_ready_q <= wr_ready_d;
            loaded_q   <= loaded_d;
            playing_q  <= playing_d;
            done_q     <= done_d;
            data_v_q   <= data_v_d;
        end
    end

    // data reads 0 from reset/LOAD until the first sample of a new table arrives.
    assign data      = zero_q ? '0 : ram_rd_data;
    assign data_v    = data_v_q;
    assign wr_ready  = wr_ready_q;
    assign loaded    = loaded_q;
    assign playing   = playing_q;
    assign done      = done_q;
    assign state_dbg = state_q;

endmodule
